// File: rtl/spi_slave_port_pkg.sv
// Shared definitions for the SPI mode-0 slave port: FSM state type,
// reserved "no device" address and the byte width.
package spi_slave_port_pkg;

  localparam int unsigned SPI_BYTE_WIDTH = 8;
  localparam logic [2:0]  SPI_NO_DEVICE  = 3'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_slv_state_e;

endpackage

// File: rtl/spi_slave_port_sync.sv
// Two-flop synchroniser plus history flop; provides the synchronised level and
// single-cycle rise/fall strobes for one asynchronous input.
module spi_slave_port_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Reset loads RST_VAL into the whole chain so a level already present on
  // the pin at reset release does not appear as a fresh edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave with built-in 3-bit address decode, oversampled inputs,
// RX holding register and one-deep TX buffer. Optional SPI_SLAVE_ECHO_EN:
// an empty TX buffer at reload sends the last received byte instead of IDLE_BYTE.
module spi_slave_port
  import spi_slave_port_pkg::*;
#(
  parameter logic [2:0]                DEVICE_ADDR = 3'd1,
  parameter logic [SPI_BYTE_WIDTH-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      spi_clk_i,
  input  logic                      mosi_i,
  input  logic [2:0]                spi_addr_i,
  output logic                      miso_o,
  output logic                      miso_oe_o,
  output logic [SPI_BYTE_WIDTH-1:0] rx_data_o,
  output logic                      rx_valid_o,
  input  logic                      rx_rd_i,
  input  logic [SPI_BYTE_WIDTH-1:0] tx_data_i,
  input  logic                      tx_load_i,
  output logic                      tx_ready_o,
  output logic                      rx_overrun_o,
  output logic                      tx_underrun_o,
  input  logic                      status_clr_i,
  output logic                      busy_o
);

  logic sel_raw;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic sel_lvl, sel_rise, sel_fall;
  logic unused_sync;

  assign sel_raw = (spi_addr_i == DEVICE_ADDR) && (DEVICE_ADDR != SPI_NO_DEVICE);

  spi_slave_port_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (spi_clk_i),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_slave_port_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (mosi_i),
    .level_o (mosi_lvl),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  // Select chain resets high: a select held through reset must drop and
  // return before it counts as a new selection.
  spi_slave_port_sync #(.RST_VAL(1'b1)) u_sync_sel (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (sel_raw),
    .level_o (sel_lvl),
    .rise_o  (sel_rise),
    .fall_o  (sel_fall)
  );

  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall, sel_lvl};

  spi_slv_state_e            state_q, state_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_WIDTH-1:0] shift_rx_q, shift_rx_d;
  logic [SPI_BYTE_WIDTH-1:0] shift_tx_q, shift_tx_d;
  logic [SPI_BYTE_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                      tx_ready_q, tx_ready_d;
  logic [SPI_BYTE_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      rx_overrun_q, rx_overrun_d;
  logic                      tx_underrun_q, tx_underrun_d;
  logic                      miso_q, miso_d;
  logic                      miso_oe_q, miso_oe_d;
  logic                      reload;
  logic                      overrun_set;
  logic                      underrun_set;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_rx_d   = shift_rx_q;
    shift_tx_d   = shift_tx_q;
    tx_buf_d     = tx_buf_q;
    tx_ready_d   = tx_ready_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rx_rd_i;
    reload       = 1'b0;
    overrun_set  = 1'b0;
    underrun_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel_rise) begin
          state_d   = SHIFT;
          bit_cnt_d = 3'd0;
          reload    = 1'b1;
        end
      end
      SHIFT: begin
        if (sel_fall) begin
          // Partial byte is dropped; RX holding register is left untouched.
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
          shift_rx_d = {shift_rx_q[SPI_BYTE_WIDTH-2:0], mosi_lvl};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d   = {shift_rx_q[SPI_BYTE_WIDTH-2:0], mosi_lvl};
            rx_valid_d  = 1'b1;
            overrun_set = rx_valid_q & ~rx_rd_i;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != 3'd0) begin
            shift_tx_d = shift_tx_q << 1;
          end else begin
            reload = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reload takes the buffer as it stood before any same-cycle tx_load_i.
    if (reload) begin
      tx_ready_d = 1'b1;
      if (!tx_ready_q) begin
        shift_tx_d = tx_buf_q;
      end else begin
`ifdef SPI_SLAVE_ECHO_EN
        shift_tx_d = rx_data_q;
`else
        shift_tx_d   = IDLE_BYTE;
        underrun_set = 1'b1;
`endif
      end
    end

    if (tx_load_i) begin
      tx_buf_d   = tx_data_i;
      tx_ready_d = 1'b0;
    end

    rx_overrun_d  = (rx_overrun_q & ~status_clr_i) | overrun_set;
    tx_underrun_d = (tx_underrun_q & ~status_clr_i) | underrun_set;

    miso_oe_d = (state_d == SHIFT);
    miso_d    = (state_d == SHIFT) ? shift_tx_d[SPI_BYTE_WIDTH-1] : 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      tx_ready_q    <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b1;
      miso_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_ready_q    <= tx_ready_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
    end
    shift_rx_q <= shift_rx_d;
    shift_tx_q <= shift_tx_d;
    tx_buf_q   <= tx_buf_d;
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = miso_oe_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = tx_ready_q;
  assign rx_overrun_o  = rx_overrun_q;
  assign tx_underrun_o = tx_underrun_q;
  assign busy_o        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: SPI master model at clk_i/16 with a
// scoreboard queue of expected RX bytes checked by an independent monitor.
module tb_spi_slave_port;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       spi_clk_i = 1'b0;
  logic       mosi_i = 1'b0;
  logic [2:0] spi_addr_i = 3'd0;
  logic       miso_o;
  logic       miso_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_rd_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_load_i = 1'b0;
  logic       tx_ready_o;
  logic       rx_overrun_o;
  logic       tx_underrun_o;
  logic       status_clr_i = 1'b0;
  logic       busy_o;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  spi_slave_port #(.DEVICE_ADDR(3'd1), .IDLE_BYTE(8'hFF)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .spi_clk_i     (spi_clk_i),
    .mosi_i        (mosi_i),
    .spi_addr_i    (spi_addr_i),
    .miso_o        (miso_o),
    .miso_oe_o     (miso_oe_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_rd_i       (rx_rd_i),
    .tx_data_i     (tx_data_i),
    .tx_load_i     (tx_load_i),
    .tx_ready_o    (tx_ready_o),
    .rx_overrun_o  (rx_overrun_o),
    .tx_underrun_o (tx_underrun_o),
    .status_clr_i  (status_clr_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Transfer n bits MSB-first. Pulses on the last bit land in the cycle the
  // DUT completes the byte (two negedges after the last rising sclk).
  task automatic spi_xfer(input logic [7:0] b, input int n, input bit chk_vld,
                          input bit rd_pulse, input bit clr_pulse,
                          output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi_i = b[7-i];
      clks(8);
      miso_b[7-i] = miso_o;
      spi_clk_i = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk_i);
        if (i == 7 && k == 2) begin
          rx_rd_i = rd_pulse;
          status_clr_i = clr_pulse;
        end
        if (k == 3) begin
          rx_rd_i = 1'b0;
          status_clr_i = 1'b0;
        end
        if (i == 7 && k == 4 && chk_vld) chk("rx_valid_4clk", rx_valid_o, 1);
      end
      spi_clk_i = 1'b0;
    end
    clks(8);
  endtask

  task automatic tx_load(input logic [7:0] d);
    tx_data_i = d;
    tx_load_i = 1'b1;
    clks(1);
    tx_load_i = 1'b0;
  endtask

  task automatic pulse_rd();
    rx_rd_i = 1'b1;
    clks(1);
    rx_rd_i = 1'b0;
  endtask

  task automatic pulse_clr();
    status_clr_i = 1'b1;
    clks(1);
    status_clr_i = 1'b0;
  endtask

  // Scoreboard monitor: a new byte is presented when rx_valid_o rises or
  // rx_data_o changes while valid.
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;
  initial begin
    forever begin
      @(negedge clk_i);
      if (!reset_i && rx_valid_o && (!prev_v || rx_data_o != prev_d)) begin
        if (exp_q.size() == 0) begin
          chk("rx_unexpected", {24'h0, rx_data_o}, 32'hFFFF_FFFF);
        end else begin
          chk("rx_byte", rx_data_o, exp_q.pop_front());
        end
      end
      prev_v = rx_valid_o;
      prev_d = rx_data_o;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] m;
    logic [7:0] exp_m0, exp_m1;

    clks(3);
    chk("rst_miso", miso_o, 1);
    chk("rst_oe", miso_oe_o, 0);
    chk("rst_busy", busy_o, 0);
    reset_i = 1'b0;
    clks(6);
    chk("rst_rx_data", rx_data_o, 8'h00);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_tx_ready", tx_ready_o, 1);
    chk("rst_flags", {rx_overrun_o, tx_underrun_o}, 2'b00);

    // Test 1: 0xA5 in, 0x3C out
    tx_load(8'h3C);
    chk("t1_tx_ready_full", tx_ready_o, 0);
    spi_addr_i = 3'd1;
    clks(8);
    chk("t1_busy", busy_o, 1);
    chk("t1_oe", miso_oe_o, 1);
    exp_q.push_back(8'hA5);
    spi_xfer(8'hA5, 8, 1'b1, 1'b0, 1'b0, m);
    chk("t1_miso", m, 8'h3C);
    chk("t1_rx_data", rx_data_o, 8'hA5);
    chk("t1_tx_ready", tx_ready_o, 1);
`ifdef SPI_SLAVE_ECHO_EN
    chk("t1_underrun", tx_underrun_o, 0);
`else
    chk("t1_underrun", tx_underrun_o, 1);
`endif
    spi_addr_i = 3'd0;
    clks(8);
    chk("t1_oe_off", miso_oe_o, 0);
    chk("t1_idle", busy_o, 0);
    pulse_rd();
    clks(1);
    chk("t1_rd_clear", rx_valid_o, 0);
    pulse_clr();

    // Test 2: back-to-back 0x12, 0x34, empty TX, no reads
`ifdef SPI_SLAVE_ECHO_EN
    exp_m0 = 8'hA5;
    exp_m1 = 8'h12;
`else
    exp_m0 = 8'hFF;
    exp_m1 = 8'hFF;
`endif
    spi_addr_i = 3'd1;
    clks(8);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    spi_xfer(8'h12, 8, 1'b0, 1'b0, 1'b0, m);
    chk("t2_miso0", m, exp_m0);
    spi_xfer(8'h34, 8, 1'b0, 1'b0, 1'b0, m);
    chk("t2_miso1", m, exp_m1);
    chk("t2_rx_data", rx_data_o, 8'h34);
    chk("t2_overrun", rx_overrun_o, 1);
`ifdef SPI_SLAVE_ECHO_EN
    chk("t2_underrun", tx_underrun_o, 0);
`else
    chk("t2_underrun", tx_underrun_o, 1);
`endif
    spi_addr_i = 3'd0;
    clks(8);
    pulse_rd();
    pulse_clr();
    clks(1);
    chk("t2_clr", {rx_overrun_o, tx_underrun_o}, 2'b00);

    // Test 3: 5 bits of 0xF0 then deselect, then full 0x81
    spi_addr_i = 3'd1;
    clks(8);
    spi_xfer(8'hF0, 5, 1'b0, 1'b0, 1'b0, m);
    spi_addr_i = 3'd0;
    clks(8);
    chk("t3_partial_valid", rx_valid_o, 0);
    chk("t3_partial_idle", busy_o, 0);
    tx_load(8'h5A);
    spi_addr_i = 3'd1;
    clks(8);
    exp_q.push_back(8'h81);
    spi_xfer(8'h81, 8, 1'b0, 1'b0, 1'b0, m);
    chk("t3_miso", m, 8'h5A);
    chk("t3_rx_data", rx_data_o, 8'h81);
    chk("t3_overrun", rx_overrun_o, 0);
    spi_addr_i = 3'd0;
    clks(8);
    pulse_rd();

    // Test 4: another device's address
    spi_addr_i = 3'd2;
    clks(8);
    spi_xfer(8'h55, 8, 1'b0, 1'b0, 1'b0, m);
    chk("t4_oe", miso_oe_o, 0);
    chk("t4_valid", rx_valid_o, 0);
    chk("t4_busy", busy_o, 0);
    spi_addr_i = 3'd0;
    clks(8);

    // Test 5: reset at bit 3 with select held
    spi_addr_i = 3'd1;
    clks(8);
    spi_xfer(8'hE7, 3, 1'b0, 1'b0, 1'b0, m);
    reset_i = 1'b1;
    clks(1);
    chk("t5_miso", miso_o, 1);
    chk("t5_oe", miso_oe_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_rx_data", rx_data_o, 8'h00);
    chk("t5_ready", tx_ready_o, 1);
    chk("t5_flags", {rx_overrun_o, tx_underrun_o}, 2'b00);
    reset_i = 1'b0;
    clks(8);
    chk("t5_no_reselect", busy_o, 0);
    spi_addr_i = 3'd0;
    clks(8);
    tx_load(8'h96);
    spi_addr_i = 3'd1;
    clks(8);
    exp_q.push_back(8'hC3);
    spi_xfer(8'hC3, 8, 1'b0, 1'b0, 1'b0, m);
    chk("t5_miso_after", m, 8'h96);
    chk("t5_rx_data_after", rx_data_o, 8'hC3);
    spi_addr_i = 3'd0;
    clks(8);
    pulse_rd();
    pulse_clr();

    // Test 6: read coincident with completion, clear coincident with overrun
    spi_addr_i = 3'd1;
    clks(8);
    exp_q.push_back(8'h6B);
    exp_q.push_back(8'h9D);
    exp_q.push_back(8'h2E);
    spi_xfer(8'h6B, 8, 1'b0, 1'b0, 1'b0, m);
    spi_xfer(8'h9D, 8, 1'b0, 1'b1, 1'b0, m);
    chk("t6_valid_kept", rx_valid_o, 1);
    chk("t6_no_overrun", rx_overrun_o, 0);
    chk("t6_rx_data", rx_data_o, 8'h9D);
    spi_xfer(8'h2E, 8, 1'b0, 1'b0, 1'b1, m);
    chk("t6_overrun_wins", rx_overrun_o, 1);
    chk("t6_rx_data2", rx_data_o, 8'h2E);
    spi_addr_i = 3'd0;
    clks(8);
    pulse_rd();
    clks(4);
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
